pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard controller for the in-order RV32 pipeline: scoreboard of in-flight writers after ID.
//  Generates load-use stall, branch/jump redirect flush and per-operand forwarding select + data.
//  Sits beside the ID/EX boundary; core stage registers obey its stall/flush/fwd outputs.
// PARAMETERS
//  XLEN       32  datapath width
//  NREG       32  architectural registers; REGW = $clog2(NREG)
//  DEPTH      3   tracked stages after ID (0=EX,1=MEM,2=WB)
//  LOAD_STAGE 1   first stage index whose load result is forwardable
//  BR_STAGE   1   stage index where redirect is raised; 1 <= BR_STAGE < DEPTH
// PORTS
//  clk            in   1           pipeline clock
//  rst_n          in   1           synchronous reset, active low
//  id_valid       in   1           ID holds a real instruction
//  id_rs1/id_rs2  in   REGW        source registers of ID instruction
//  id_use1/id_use2 in  1           source actually read
//  id_rd          in   REGW        destination of ID instruction
//  id_wen         in   1           ID instruction writes rd
//  id_load        in   1           ID instruction is a load
//  rf_rdata1/2    in   XLEN        register-file read data
//  st_data        in   DEPTH*XLEN  result of stage k at bits [k*XLEN +: XLEN]
//  redirect       in   1           instruction in stage BR_STAGE changes PC (taken branch/jal)
//  stall_fe       out  1           hold PC and IF/ID register
//  flush_fe       out  1           squash IF/ID register next edge
//  fwd_sel1/2     out  $clog2(DEPTH+1) 0=register file, k+1=stage k
//  fwd_data1/2    out  XLEN        operand after forwarding mux
//  perf_stall_cnt out  32          stall cycles (HAZ_PERF_EN)
//  perf_flush_cnt out  32          redirects (HAZ_PERF_EN)
// BEHAVIOUR
//  - Scoreboard st[k] = {vld, rd, wen, load}, k=0..DEPTH-1; advances every posedge clk.
//  - rst_n=0 at edge: all st[k].vld=0, counters=0; hence stall_fe=0, flush_fe=0, fwd_sel=0 next cycle.
//  - match(k,rs) = st[k].vld & st[k].wen & rd==rs & rs!=0 & use; x0 never matches.
//  - stall_fe (comb) = id_valid & !redirect & exists k<LOAD_STAGE: match & st[k].load.
//  - fwd_sel (comb): lowest k with match (youngest wins); 0 if none or when matched entry is an
//    unforwardable load (k<LOAD_STAGE; stall covers it). fwd_data = mux(rf_rdata, st_data[k]).
//  - Edge update: st[k]<=st[k-1] for k>=1; st[0]<=ID entry, or bubble (vld=0) if !id_valid|stall_fe|redirect.
//  - redirect: flush_fe=1 same cycle (comb); at edge st[1..BR_STAGE] receive vld=0 (kills younger).
//  - redirect & load-use same cycle: redirect wins, stall_fe=0.
//  - Entries leaving stage DEPTH-1 are dropped; register-file write in same cycle as ID read is not
//    forwarded here (regfile is write-first).
//  - Latency: stall is exactly one cycle per LOAD_STAGE-k gap; load at k=0, LOAD_STAGE=1 -> 1 bubble.
// CONFIGURATION
//  HAZ_PERF_EN defined: perf_stall_cnt +1 on every cycle stall_fe=1; perf_flush_cnt +1 per redirect
//    cycle; both wrap at 2^32, clear on reset.
//  HAZ_PERF_EN undefined: both counters tied to 32'd0, no flops.
// STRUCTURE
//  Shared package rv_pipe_pkg: opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL),
//    scoreboard entry struct / field widths, FWD_RF=0 constant.
//  One sub-module: hazard_fwd_mux (per-operand priority match + data mux), instantiated twice.
// TESTING
//  1 add x5 in EX, ID add x6,x5,x1, st_data[EX]=0x11 -> fwd_sel1=1, fwd_data1=0x11, no stall.
//  2 lw x7 in EX, ID uses x7 -> stall_fe=1 one cycle, st[0] bubble; next cycle fwd_sel=2 (MEM).
//  3 x5 writer in EX and MEM, st_data=0xA/0xB -> youngest wins: fwd_data=0xA.
//  4 writer rd=x0, ID reads x0, rf_rdata=0 -> fwd_sel=0, fwd_data=0.
//  5 redirect with lw hazard pending -> flush_fe=1, stall_fe=0; next cycle st[0..1].vld=0.
//  6 rst_n=0 mid-stream with 3 valid entries -> next cycle no fwd/stall; HAZ_PERF_EN counters = 0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared RV32 pipeline definitions: opcodes, scoreboard entry layout, forwarding select encoding.
package rv_pipe_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int SB_REGW = 5;
   localparam int FWD_RF  = 0;

   typedef struct packed {
      logic               vld;
      logic [SB_REGW-1:0] rd;
      logic               wen;
      logic               load;
   } sb_entry_t;

endpackage

// File: rtl/hazard_fwd_mux.sv
// Per-operand priority match against the scoreboard: youngest writer wins, and a
// load that cannot be forwarded yet is reported so the top can stall.
module hazard_fwd_mux
   import rv_pipe_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REGW       = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 1,
   parameter int SELW       = $clog2(DEPTH+1)
) (
   input  logic [DEPTH-1:0]            sb_vld,
   input  logic [DEPTH-1:0][REGW-1:0]  sb_rd,
   input  logic [DEPTH-1:0]            sb_wen,
   input  logic [DEPTH-1:0]            sb_load,
   input  logic [REGW-1:0]             rs,
   input  logic                        use_rs,
   input  logic [XLEN-1:0]             rf_rdata,
   input  logic [DEPTH*XLEN-1:0]       st_data,
   output logic [SELW-1:0]             fwd_sel,
   output logic [XLEN-1:0]             fwd_data,
   output logic                        load_hit
);

   logic found;
   logic hit;

   always_comb begin
      fwd_sel  = SELW'(FWD_RF);
      fwd_data = rf_rdata;
      load_hit = 1'b0;
      found    = 1'b0;
      hit      = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         hit = sb_vld[k] & sb_wen[k] & (sb_rd[k] == rs) & (rs != '0) & use_rs;
         if (hit && (k < LOAD_STAGE) && sb_load[k])
            load_hit = 1'b1;
         // only the youngest match decides the mux; an unforwardable load leaves the RF path
         if (hit && !found) begin
            found = 1'b1;
            if (!((k < LOAD_STAGE) && sb_load[k])) begin
               fwd_sel  = SELW'(k + 1);
               fwd_data = st_data[k*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside ID/EX: in-flight writer scoreboard, load-use stall, redirect flush, forwarding.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 1,
   parameter int BR_STAGE   = 1,
   parameter int REGW       = $clog2(NREG),
   parameter int SELW       = $clog2(DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REGW-1:0]       id_rs1,
   input  logic [REGW-1:0]       id_rs2,
   input  logic                  id_use1,
   input  logic                  id_use2,
   input  logic [REGW-1:0]       id_rd,
   input  logic                  id_wen,
   input  logic                  id_load,
   input  logic [XLEN-1:0]       rf_rdata1,
   input  logic [XLEN-1:0]       rf_rdata2,
   input  logic [DEPTH*XLEN-1:0] st_data,
   input  logic                  redirect,
   output logic                  stall_fe,
   output logic                  flush_fe,
   output logic [SELW-1:0]       fwd_sel1,
   output logic [SELW-1:0]       fwd_sel2,
   output logic [XLEN-1:0]       fwd_data1,
   output logic [XLEN-1:0]       fwd_data2,
   output logic [31:0]           perf_stall_cnt,
   output logic [31:0]           perf_flush_cnt
);

   logic [DEPTH-1:0]           sb_vld;
   logic [DEPTH-1:0][REGW-1:0] sb_rd;
   logic [DEPTH-1:0]           sb_wen;
   logic [DEPTH-1:0]           sb_load;
   logic                       load_hit1;
   logic                       load_hit2;

   hazard_fwd_mux #(
      .XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)
   ) u_fwd1 (
      .sb_vld(sb_vld), .sb_rd(sb_rd), .sb_wen(sb_wen), .sb_load(sb_load),
      .rs(id_rs1), .use_rs(id_use1), .rf_rdata(rf_rdata1), .st_data(st_data),
      .fwd_sel(fwd_sel1), .fwd_data(fwd_data1), .load_hit(load_hit1)
   );

   hazard_fwd_mux #(
      .XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SELW(SELW)
   ) u_fwd2 (
      .sb_vld(sb_vld), .sb_rd(sb_rd), .sb_wen(sb_wen), .sb_load(sb_load),
      .rs(id_rs2), .use_rs(id_use2), .rf_rdata(rf_rdata2), .st_data(st_data),
      .fwd_sel(fwd_sel2), .fwd_data(fwd_data2), .load_hit(load_hit2)
   );

   // redirect overrides a pending load-use stall: the stalled instruction is being squashed anyway
   assign stall_fe = id_valid & ~redirect & (load_hit1 | load_hit2);
   assign flush_fe = redirect;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_vld  <= '0;
         sb_rd   <= '0;
         sb_wen  <= '0;
         sb_load <= '0;
      end else begin
         for (int k = DEPTH-1; k >= 1; k--) begin
            sb_vld[k]  <= sb_vld[k-1] & ~(redirect & (k <= BR_STAGE));
            sb_rd[k]   <= sb_rd[k-1];
            sb_wen[k]  <= sb_wen[k-1];
            sb_load[k] <= sb_load[k-1];
         end
         sb_vld[0]  <= id_valid & ~stall_fe & ~redirect;
         sb_rd[0]   <= id_rd;
         sb_wen[0]  <= id_wen;
         sb_load[0] <= id_load;
      end
   end

`ifdef HAZ_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         perf_stall_cnt <= perf_stall_cnt + {31'd0, stall_fe};
         perf_flush_cnt <= perf_flush_cnt + {31'd0, redirect};
      end
   end
`else
   assign perf_stall_cnt = 32'd0;
   assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic.
module tb_pipe_hazard_ctrl;

   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REGW       = 5;
   localparam int DEPTH      = 3;
   localparam int LOAD_STAGE = 1;
   localparam int BR_STAGE   = 1;
   localparam int SELW       = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  id_valid;
   logic [REGW-1:0]       id_rs1, id_rs2, id_rd;
   logic                  id_use1, id_use2, id_wen, id_load;
   logic [XLEN-1:0]       rf_rdata1, rf_rdata2;
   logic [DEPTH*XLEN-1:0] st_data;
   logic                  redirect;
   logic                  stall_fe, flush_fe;
   logic [SELW-1:0]       fwd_sel1, fwd_sel2;
   logic [XLEN-1:0]       fwd_data1, fwd_data2;
   logic [31:0]           perf_stall_cnt, perf_flush_cnt;

   pipe_hazard_ctrl #(
      .XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .BR_STAGE(BR_STAGE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .id_rd(id_rd), .id_wen(id_wen), .id_load(id_load),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .st_data(st_data),
      .redirect(redirect), .stall_fe(stall_fe), .flush_fe(flush_fe),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          stall;
      bit          flush;
      int          sel1;
      int          sel2;
      logic [31:0] d1;
      logic [31:0] d2;
   } exp_t;

   typedef struct {
      int rd;
      bit wen;
      bit load;
   } instr_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // in-flight instructions by age: slot 0 = EX, 1 = MEM, 2 = WB; a bubble is an invalid slot
   bit     m_vld[DEPTH];
   instr_t m_ins[DEPTH];
   int unsigned m_stall_cnt, m_flush_cnt;

   function automatic void chk(string name, longint act, longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   // youngest in-flight writer of rs supplies the operand, unless it is a load not yet available
   function automatic int ref_sel(int rs, bit use_r);
      if (!use_r || rs == 0) return 0;
      for (int age = 0; age < DEPTH; age++)
         if (m_vld[age] && m_ins[age].wen && m_ins[age].rd == rs)
            return (m_ins[age].load && age < LOAD_STAGE) ? 0 : age + 1;
      return 0;
   endfunction

   function automatic bit ref_load_wait(int rs, bit use_r);
      if (!use_r || rs == 0) return 0;
      for (int age = 0; age < LOAD_STAGE; age++)
         if (m_vld[age] && m_ins[age].wen && m_ins[age].load && m_ins[age].rd == rs)
            return 1;
      return 0;
   endfunction

   task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit wen, input bit ld, input bit redir, input bit rstn);
      exp_t e;
      instr_t ni;
      rst_n     = rstn;
      id_valid  = v;
      id_rs1    = REGW'(rs1);
      id_rs2    = REGW'(rs2);
      id_use1   = u1;
      id_use2   = u2;
      id_rd     = REGW'(rd);
      id_wen    = wen;
      id_load   = ld;
      redirect  = redir;
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      st_data   = {$urandom, $urandom, $urandom};
      e.flush = redir;
      e.stall = v && !redir && (ref_load_wait(rs1, u1) || ref_load_wait(rs2, u2));
      e.sel1  = ref_sel(rs1, u1);
      e.sel2  = ref_sel(rs2, u2);
      e.d1    = (e.sel1 == 0) ? rf_rdata1 : st_data[(e.sel1-1)*XLEN +: XLEN];
      e.d2    = (e.sel2 == 0) ? rf_rdata2 : st_data[(e.sel2-1)*XLEN +: XLEN];
      exp_q.push_back(e);
      @(posedge clk);
      if (!rstn) begin
         foreach (m_vld[i]) m_vld[i] = 0;
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         m_stall_cnt += e.stall;
         m_flush_cnt += redir;
         for (int age = DEPTH-1; age >= 1; age--) begin
            m_vld[age] = m_vld[age-1] && !(redir && age <= BR_STAGE);
            m_ins[age] = m_ins[age-1];
         end
         ni.rd = rd; ni.wen = wen; ni.load = ld;
         m_ins[0] = ni;
         m_vld[0] = v && !e.stall && !redir;
      end
      #1;
   endtask

   task automatic chk_perf(string tag);
`ifdef HAZ_PERF_EN
      chk({tag, "_stall_cnt"}, perf_stall_cnt, m_stall_cnt);
      chk({tag, "_flush_cnt"}, perf_flush_cnt, m_flush_cnt);
`else
      chk({tag, "_stall_cnt"}, perf_stall_cnt, 0);
      chk({tag, "_flush_cnt"}, perf_flush_cnt, 0);
`endif
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("stall_fe",  stall_fe,  e.stall);
         chk("flush_fe",  flush_fe,  e.flush);
         chk("fwd_sel1",  fwd_sel1,  e.sel1);
         chk("fwd_sel2",  fwd_sel2,  e.sel2);
         chk("fwd_data1", fwd_data1, e.d1);
         chk("fwd_data2", fwd_data2, e.d2);
      end
   end

   initial begin
      rst_n = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
      id_rd = 0; id_wen = 0; id_load = 0; redirect = 0;
      rf_rdata1 = 0; rf_rdata2 = 0; st_data = '0;
      foreach (m_vld[i]) m_vld[i] = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_perf("reset");

      // add x5 in EX, then add x6,x5,x1
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
      step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
      // lw x7, dependent use stalls once then forwards from MEM
      step(1, 1, 2, 1, 1, 7, 1, 1, 0, 1);
      step(1, 7, 0, 1, 0, 8, 1, 0, 0, 1);
      step(1, 7, 0, 1, 0, 8, 1, 0, 0, 1);
      // two writers of x5: youngest supplies the operand
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
      step(1, 5, 5, 1, 1, 9, 1, 0, 0, 1);
      // writer of x0 never forwards
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      step(1, 0, 0, 1, 1, 3, 1, 0, 0, 1);
      // redirect with a load hazard pending
      step(1, 0, 0, 0, 0, 7, 1, 1, 0, 1);
      step(1, 7, 7, 1, 1, 4, 1, 0, 1, 1);
      step(1, 7, 4, 1, 1, 2, 1, 0, 0, 1);
      // reset with three live writers
      step(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 11, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 12, 1, 1, 0, 1);
      step(1, 10, 11, 1, 1, 13, 1, 0, 0, 0);
      step(1, 12, 11, 1, 1, 13, 1, 0, 0, 1);
      chk_perf("midreset");

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) != 0,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
         if (i % 100 == 99) chk_perf("random");
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
